line_conv2d_sequencer: RTL and testbench
========================================

// Module: line_conv2d_sequencer
// PURPOSE
//  Parametrised control sequencer for a line conv2d engine built from NUM_KCPE kernel-channel PEs.
//  It replaces the fixed inline control logic with an explicit FSM, adding:
//  - line/column fetch counters with a gated end-of-line flag;
//  - kernel-row weight sequencing and a NUM_KCPE-beat weight fetch burst;
//  - completion detection, enable freeze, soft clear and an underrun error flag.
//  It sits between the external data/weight feeders and the input/weight buffers.
// PARAMETERS
//  NUM_KCPE          3   PEs per line; length of the o_weight_req burst
//  NUM_KCPE_WIDTH    2   width of the burst counter; must satisfy 2**NUM_KCPE_WIDTH > NUM_KCPE
//  REG_WIDTH         32  width of the config registers and the psum counters
//  CNT_WIDTH         16  width of the column and line counters
//  KERNEL_SIZE_WIDTH 4   width of the kernel-row counter
// PORTS
//  clk                    in   1                  clock
//  rst                    in   1                  asynchronous active-low reset
//  i_conf_ctrl            in   REG_WIDTH          [0] enb, [1] start (level, edge-detected), [2] soft clear
//  i_conf_weightinterval  in   REG_WIDTH          psums per kernel row, minus 1
//  i_conf_kernelshape     in   REG_WIDTH          [KERNEL_SIZE_WIDTH-1:0] kernel rows, minus 1
//  i_conf_inputshape      in   REG_WIDTH          [CNT_WIDTH-1:0] columns/line - 1; [CNT_WIDTH+15:CNT_WIDTH] lines - 1
//  i_conf_numpsum         in   REG_WIDTH          total psums per job, minus 1
//  i_buf_full             in   1                  input buffer full
//  i_buf_empty            in   1                  input buffer empty
//  i_psum_val             in   1                  PE0 psum valid
//  o_data_req             out  1                  external activation request
//  o_data_end             out  1                  last column of a line being requested
//  o_buf_data_req         out  1                  input buffer pop
//  o_buf_weight_req       out  1                  weight buffer pop
//  o_weight_req           out  1                  external weight fetch
//  o_busy                 out  1                  FSM is not IDLE
//  o_done                 out  1                  one-cycle job-complete pulse
//  o_err_underrun         out  1                  sticky underrun flag
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is asynchronous and active-low.
//  - On reset, every register and every output is 0 and the FSM is IDLE.
//  - Reset asserted mid-job aborts the job immediately; no o_done is produced.
//  Enable, clear and start
//  - enb=0: FSM and all counters hold, and all req outputs are forced to 0.
//  - Soft clear (bit 2) is synchronous. It overrides everything: FSM to IDLE, all counters and the error flag cleared.
//  - start is recognised only on a rising edge of bit 1, only in IDLE and only with enb=1. A start seen while busy is ignored.
//  FSM states
//  - IDLE: a start edge clears the counters and moves to PRELOAD.
//  - PRELOAD: when i_buf_full=1, o_buf_data_req and o_buf_weight_req pulse for one cycle, then go to RUN.
//  - RUN:
//    - o_buf_data_req = i_psum_val (combinational).
//    - Each i_psum_val increments psum_cnt and tot_cnt.
//    - When psum_cnt == weightinterval on a valid psum: psum_cnt wraps to 0, o_buf_weight_req pulses the next cycle, krow_cnt increments.
//    - When krow_cnt == kernelshape on that wrap: krow_cnt wraps to 0 and o_weight_req is held high for exactly NUM_KCPE cycles.
//    - When tot_cnt == numpsum on a valid psum, go to DONE. This has priority: no weight pulse or burst is started in that cycle.
//  - DONE: o_done=1 for one cycle, then go to IDLE. Any o_weight_req burst in progress is truncated.
//  Data fetch
//  - o_data_req is registered: set to (state is PRELOAD or RUN) & ~i_buf_full & ~fetch_done.
//  - col_cnt increments on each cycle with o_data_req=1.
//  - o_data_end = o_data_req & (col_cnt == cols-1); it is gated and never asserts while idle.
//  - At column wrap, col_cnt goes to 0 and line_cnt increments.
//  - On o_data_end of the last line, fetch_done is set and o_data_req stays 0 until the next start.
//  Error and width rules
//  - i_psum_val=1 while i_buf_empty=1 in RUN sets o_err_underrun. It is cleared only by start or soft clear.
//  - All counters wrap by compare, never by overflow.
//  - Config values are sampled continuously and must be held stable while o_busy=1.
// TESTING
//  1. cols-1=3, lines-1=1, buffer never full
//     -> o_data_req high for 8 cycles; o_data_end on request beats 4 and 8; then o_data_req stays 0.
//  2. i_buf_full rises 5 cycles after start
//     -> o_buf_data_req and o_buf_weight_req each pulse once in the same cycle; state enters RUN.
//  3. weightinterval=2, kernelshape=1, NUM_KCPE=3, numpsum=11, psum valid every cycle
//     -> o_buf_weight_req after psums 3, 6, 9; o_weight_req 3-cycle burst after psum 6;
//        psum 12 raises o_done and suppresses the pulse after psum 12.
//  4. enb dropped for 4 cycles mid-RUN -> all counters hold; no psum or weight pulse is lost after enb returns.
//  5. i_psum_val with i_buf_empty=1 -> o_err_underrun stays 1 through o_done and clears on the next start.
//  6. rst low mid-burst, and separately soft clear mid-RUN
//     -> all outputs 0 immediately (async), or on the next edge (soft clear); a new start runs cleanly.

Source files
------------

// File: rtl/line_conv2d_sequencer.sv
// line_conv2d_sequencer: control FSM for a line conv2d engine.
// It requests activation lines from the external feeder, pops the input and
// weight buffers in step with PE0 psums, runs the NUM_KCPE-beat external
// weight fetch at each kernel-row wrap, and flags job completion and underrun.
module line_conv2d_sequencer #(
  parameter int NUM_KCPE          = 3,
  parameter int NUM_KCPE_WIDTH    = 2,
  parameter int REG_WIDTH         = 32,
  parameter int CNT_WIDTH         = 16,
  parameter int KERNEL_SIZE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] i_conf_ctrl,
  input  logic [REG_WIDTH-1:0] i_conf_weightinterval,
  input  logic [REG_WIDTH-1:0] i_conf_kernelshape,
  input  logic [REG_WIDTH-1:0] i_conf_inputshape,
  input  logic [REG_WIDTH-1:0] i_conf_numpsum,
  input  logic                 i_buf_full,
  input  logic                 i_buf_empty,
  input  logic                 i_psum_val,
  output logic                 o_data_req,
  output logic                 o_data_end,
  output logic                 o_buf_data_req,
  output logic                 o_buf_weight_req,
  output logic                 o_weight_req,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err_underrun
);

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_start_d;
  logic                        r_data_req;
  logic                        r_fetch_done;
  logic [CNT_WIDTH-1:0]        r_col_cnt;
  logic [CNT_WIDTH-1:0]        r_line_cnt;
  logic [REG_WIDTH-1:0]        r_psum_cnt;
  logic [REG_WIDTH-1:0]        r_tot_cnt;
  logic [KERNEL_SIZE_WIDTH-1:0] r_krow_cnt;
  logic [NUM_KCPE_WIDTH-1:0]   r_burst_cnt;
  logic                        r_wpulse;
  logic                        r_err;

  logic                        w_enb;
  logic                        w_start;
  logic                        w_clr;
  logic                        w_start_edge;
  logic                        w_job_start;
  logic [CNT_WIDTH-1:0]        w_cols_m1;
  logic [15:0]                 w_lines_field;
  logic [CNT_WIDTH-1:0]        w_lines_m1;
  logic [KERNEL_SIZE_WIDTH-1:0] w_krows_m1;
  logic                        w_col_last;
  logic                        w_line_last;
  logic                        w_data_end;
  logic                        w_fetch_done_nxt;
  logic                        w_unused;

  assign w_enb         = i_conf_ctrl[0];
  assign w_start       = i_conf_ctrl[1];
  assign w_clr         = i_conf_ctrl[2];
  assign w_start_edge  = w_start & ~r_start_d;
  assign w_job_start   = w_enb & (r_state == S_IDLE) & w_start_edge;

  assign w_cols_m1     = i_conf_inputshape[CNT_WIDTH-1:0];
  assign w_lines_field = i_conf_inputshape[CNT_WIDTH+15:CNT_WIDTH];
  assign w_lines_m1    = CNT_WIDTH'(w_lines_field);
  assign w_krows_m1    = i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0];

  // Only the low fields of the shape/ctrl words are meaningful.
  assign w_unused = ^{i_conf_ctrl, i_conf_kernelshape, i_conf_inputshape};

  // A fetch beat happens only when the registered request is visible (enb=1).
  assign w_col_last       = (r_col_cnt == w_cols_m1);
  assign w_line_last      = (r_line_cnt == w_lines_m1);
  assign w_data_end       = w_enb & r_data_req & w_col_last & (r_state != S_IDLE);
  // Look-ahead so the request drops right after the final end-of-line beat.
  assign w_fetch_done_nxt = r_fetch_done | (w_data_end & w_line_last);

  // Start-level sampler for edge detection; tracks the bit regardless of enb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_start_d <= 1'b0;
    else      r_start_d <= w_start;
  end

  // Job FSM: psum/row/kernel-row counting, weight pulse, burst, underrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_psum_cnt  <= '0;
      r_tot_cnt   <= '0;
      r_krow_cnt  <= '0;
      r_burst_cnt <= '0;
      r_wpulse    <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_clr) begin
      r_state     <= S_IDLE;
      r_psum_cnt  <= '0;
      r_tot_cnt   <= '0;
      r_krow_cnt  <= '0;
      r_burst_cnt <= '0;
      r_wpulse    <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_enb) begin
      r_wpulse <= 1'b0;
      if (r_burst_cnt != '0) r_burst_cnt <= r_burst_cnt - 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state     <= S_PRELOAD;
            r_psum_cnt  <= '0;
            r_tot_cnt   <= '0;
            r_krow_cnt  <= '0;
            r_burst_cnt <= '0;
            r_err       <= 1'b0;
          end
        end
        S_PRELOAD: begin
          if (i_buf_full) r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_psum_val & i_buf_empty) r_err <= 1'b1;
          if (i_psum_val) begin
            if (r_tot_cnt == i_conf_numpsum) begin
              // Final psum wins: no weight pulse, burst cut short.
              r_state     <= S_DONE;
              r_burst_cnt <= '0;
            end else begin
              r_tot_cnt <= r_tot_cnt + 1'b1;
              if (r_psum_cnt == i_conf_weightinterval) begin
                r_psum_cnt <= '0;
                r_wpulse   <= 1'b1;
                if (r_krow_cnt == w_krows_m1) begin
                  r_krow_cnt  <= '0;
                  r_burst_cnt <= NUM_KCPE_WIDTH'(NUM_KCPE);
                end else begin
                  r_krow_cnt <= r_krow_cnt + 1'b1;
                end
              end else begin
                r_psum_cnt <= r_psum_cnt + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_burst_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Activation fetch: column/line counters and the registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt    <= '0;
      r_line_cnt   <= '0;
      r_fetch_done <= 1'b0;
      r_data_req   <= 1'b0;
    end else if (w_clr) begin
      r_col_cnt    <= '0;
      r_line_cnt   <= '0;
      r_fetch_done <= 1'b0;
      r_data_req   <= 1'b0;
    end else if (w_enb) begin
      if (w_job_start) begin
        r_col_cnt  <= '0;
        r_line_cnt <= '0;
      end else if (r_data_req) begin
        if (w_col_last) begin
          r_col_cnt  <= '0;
          r_line_cnt <= w_line_last ? '0 : r_line_cnt + 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
      r_fetch_done <= w_job_start ? 1'b0 : w_fetch_done_nxt;
      r_data_req   <= ((r_state == S_PRELOAD) | (r_state == S_RUN)) &
                      ~i_buf_full & ~w_fetch_done_nxt;
    end
  end

  // Requests are masked while disabled; state behind them simply holds.
  assign o_data_req       = w_enb & r_data_req;
  assign o_data_end       = w_data_end;
  assign o_buf_data_req   = w_enb & (((r_state == S_PRELOAD) & i_buf_full) |
                                     ((r_state == S_RUN) & i_psum_val));
  assign o_buf_weight_req = w_enb & (((r_state == S_PRELOAD) & i_buf_full) | r_wpulse);
  assign o_weight_req     = w_enb & (r_burst_cnt != '0);
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = w_enb & (r_state == S_DONE);
  assign o_err_underrun   = r_err;

endmodule

// File: tb/tb_line_conv2d_sequencer.sv
// Self-checking bench for line_conv2d_sequencer with a psum-index event model.
module tb_line_conv2d_sequencer;

  localparam int NUM_KCPE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl, cfg_wi, cfg_ks, cfg_is, cfg_np;
  logic        buf_full, buf_empty, psum_val;
  logic        o_data_req, o_data_end, o_buf_data_req, o_buf_weight_req;
  logic        o_weight_req, o_busy, o_done, o_err_underrun;
  logic [7:0]  outs;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  assign outs = {o_data_req, o_data_end, o_buf_data_req, o_buf_weight_req,
                 o_weight_req, o_busy, o_done, o_err_underrun};

  line_conv2d_sequencer #(
    .NUM_KCPE(NUM_KCPE), .NUM_KCPE_WIDTH(2), .REG_WIDTH(32),
    .CNT_WIDTH(16), .KERNEL_SIZE_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst_n),
    .i_conf_ctrl(ctrl), .i_conf_weightinterval(cfg_wi),
    .i_conf_kernelshape(cfg_ks), .i_conf_inputshape(cfg_is),
    .i_conf_numpsum(cfg_np),
    .i_buf_full(buf_full), .i_buf_empty(buf_empty), .i_psum_val(psum_val),
    .o_data_req(o_data_req), .o_data_end(o_data_end),
    .o_buf_data_req(o_buf_data_req), .o_buf_weight_req(o_buf_weight_req),
    .o_weight_req(o_weight_req), .o_busy(o_busy), .o_done(o_done),
    .o_err_underrun(o_err_underrun)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Leaves the bench in the first PRELOAD cycle, inputs ctrl=enb only.
  task automatic do_start();
    cyc(); ctrl = 32'h1;
    cyc(); ctrl = 32'h3;
    cyc(); ctrl = 32'h1;
  endtask

  task automatic soft_clear();
    cyc(); ctrl = 32'h5; psum_val = 1'b0;
    cyc(); ctrl = 32'h1;
    settle();
    chk_cnt++;
    if (outs !== 8'h00) $display("FAIL soft_clear_outs: got %b want 00000000", outs);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctrl = '0; cfg_wi = '0; cfg_ks = '0; cfg_is = '0; cfg_np = '0;
    buf_full = 1'b0; buf_empty = 1'b0; psum_val = 1'b0;
    cyc(); cyc(); settle();
    chk_cnt++;
    if (outs !== 8'h00) $display("FAIL reset_outs: got %b want 00000000", outs);
    else pass_cnt++;
    cyc(); rst_n = 1'b1; ctrl = 32'h1;
    cyc(); settle();
    chk_cnt++;
    if (outs !== 8'h00) $display("FAIL post_reset_idle: got %b want 00000000", outs);
    else pass_cnt++;
  endtask

  // Buffer never full: the fetch walks lines x cols beats then stops.
  task automatic test_fetch(input int cols_m1, input int lines_m1);
    int beats;
    int cols;
    bit exp_end;
    cols = cols_m1 + 1;
    cfg_is = (lines_m1 << 16) | cols_m1;
    buf_full = 1'b0; psum_val = 1'b0; buf_empty = 1'b0;
    beats = 0;
    do_start();
    for (int i = 0; i < 120; i++) begin
      cyc(); settle();
      if (o_data_req === 1'b1) begin
        beats++;
        exp_end = (beats % cols) == 0;
      end else begin
        exp_end = 1'b0;
      end
      if (o_data_end !== exp_end) begin
        chk_cnt++;
        $display("FAIL fetch_end c%0d l%0d beat%0d: got %b want %b",
                 cols_m1, lines_m1, beats, o_data_end, exp_end);
      end
    end
    chk_cnt++;
    if (beats != cols * (lines_m1 + 1))
      $display("FAIL fetch_beats c%0d l%0d: got %0d want %0d",
               cols_m1, lines_m1, beats, cols * (lines_m1 + 1));
    else pass_cnt++;
    chk_cnt++;
    if (o_busy !== 1'b1) $display("FAIL fetch_busy: got %b want 1", o_busy);
    else pass_cnt++;
    soft_clear();
  endtask

  // Buffer fills 5 cycles into PRELOAD: one coincident pop of both buffers.
  task automatic test_preload();
    int nd, nw, nboth;
    bit req_before;
    nd = 0; nw = 0; nboth = 0; req_before = 1'b0;
    cfg_is = 32'd100; buf_full = 1'b0; psum_val = 1'b0; buf_empty = 1'b0;
    do_start();
    for (int i = 0; i < 12; i++) begin
      cyc(); buf_full = (i >= 5); settle();
      if (i == 4) req_before = o_data_req;
      if (o_buf_data_req) nd++;
      if (o_buf_weight_req) nw++;
      if (o_buf_data_req && o_buf_weight_req) nboth++;
    end
    chk_cnt++;
    if (req_before !== 1'b1) $display("FAIL preload_fetching: got %b want 1", req_before);
    else pass_cnt++;
    chk_cnt++;
    if (nd != 1 || nw != 1 || nboth != 1)
      $display("FAIL preload_pulses: got d%0d w%0d both%0d want d1 w1 both1", nd, nw, nboth);
    else pass_cnt++;
    chk_cnt++;
    if ({o_busy, o_data_req} !== 2'b10)
      $display("FAIL preload_run: got busy/req %b%b want 10", o_busy, o_data_req);
    else pass_cnt++;
    soft_clear();
  endtask

  // Full job against the psum-index model. Psum n (1-based) of total np+1:
  // n multiple of (wi+1) -> weight pop next cycle; multiple of (wi+1)(ks+1)
  // -> NUM_KCPE-cycle fetch burst from next cycle; n == np+1 -> done next
  // cycle and nothing else. enb=0 cycles freeze the model and mask requests.
  task automatic run_job(input int wi, input int ks, input int np, input int pv_pct,
                         input int empty_pct, input bit gap, input bit directed);
    int n, total, burst, gap_at, npulse, nwreq, ndone, nburst;
    bit pend, done_pend, err, finished, enb, pv, be, npend;
    cfg_wi = wi; cfg_ks = ks; cfg_np = np; cfg_is = 32'd3;
    buf_full = 1'b1; buf_empty = 1'b0; psum_val = 1'b0;
    n = 0; total = np + 1; burst = 0; pend = 0; done_pend = 0; err = 0;
    finished = 0; npulse = 0; nwreq = 0; ndone = 0;
    gap_at = gap ? $urandom_range(3, 8) : -100;
    do_start();
    settle();
    chk_cnt++;
    if ({o_buf_data_req, o_buf_weight_req, o_err_underrun, o_busy} !== 4'b1101)
      $display("FAIL job_preload_pop: got %b%b%b%b want 1101",
               o_buf_data_req, o_buf_weight_req, o_err_underrun, o_busy);
    else pass_cnt++;
    for (int c = 0; c < 400 && !finished; c++) begin
      cyc();
      enb = !(c >= gap_at && c < gap_at + 4);
      pv  = done_pend ? 1'b0 : ($urandom_range(0, 99) < pv_pct);
      be  = $urandom_range(0, 99) < empty_pct;
      ctrl = {31'd0, enb}; psum_val = pv; buf_empty = be;
      settle();
      chk_cnt++;
      if ({o_buf_data_req, o_buf_weight_req, o_weight_req, o_done, o_err_underrun, o_data_req} !==
          {enb & pv, enb & pend, enb & (burst > 0), enb & done_pend, err, 1'b0})
        $display("FAIL job_cycle wi%0d ks%0d np%0d c%0d psum%0d: got bdr%b bwr%b wr%b done%b err%b dreq%b want bdr%b bwr%b wr%b done%b err%b dreq0",
                 wi, ks, np, c, n, o_buf_data_req, o_buf_weight_req, o_weight_req, o_done,
                 o_err_underrun, o_data_req, enb & pv, enb & pend, enb & (burst > 0),
                 enb & done_pend, err);
      else pass_cnt++;
      if (enb & pend) npulse++;
      if (enb & (burst > 0)) nwreq++;
      if (o_done) ndone++;
      if (enb) begin
        if (done_pend) begin
          finished = 1;
        end else begin
          if (pv && be) err = 1;
          npend = 0;
          nburst = (burst > 0) ? burst - 1 : 0;
          if (pv) begin
            n++;
            if (n == total) begin
              done_pend = 1; nburst = 0;
            end else begin
              if (n % (wi + 1) == 0) npend = 1;
              if (n % ((wi + 1) * (ks + 1)) == 0) nburst = NUM_KCPE;
            end
          end
          pend = npend; burst = nburst;
        end
      end
    end
    chk_cnt++;
    if (!finished) $display("FAIL job_timeout wi%0d ks%0d np%0d: got no done want done", wi, ks, np);
    else pass_cnt++;
    cyc(); ctrl = 32'h1; psum_val = 1'b0; buf_empty = 1'b0;
    settle();
    chk_cnt++;
    if ({o_busy, o_done, o_err_underrun} !== {2'b00, err})
      $display("FAIL job_end: got busy%b done%b err%b want busy0 done0 err%b",
               o_busy, o_done, o_err_underrun, err);
    else pass_cnt++;
    if (directed) begin
      chk_cnt++;
      if (npulse != 3 || nwreq != 3 || ndone != 1)
        $display("FAIL directed_counts: got pulses%0d wreq%0d done%0d want 3 3 1",
                 npulse, nwreq, ndone);
      else pass_cnt++;
    end
  endtask

  // Async reset in the middle of a fetch burst, then a clean job.
  task automatic test_reset_midburst();
    cfg_wi = 0; cfg_ks = 0; cfg_np = 50;
    buf_full = 1'b1; buf_empty = 1'b0; psum_val = 1'b0;
    do_start();
    repeat (3) begin cyc(); psum_val = 1'b1; end
    settle();
    chk_cnt++;
    if (o_weight_req !== 1'b1) $display("FAIL midburst_active: got %b want 1", o_weight_req);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (outs !== 8'h00) $display("FAIL async_reset_outs: got %b want 00000000", outs);
    else pass_cnt++;
    cyc(); cyc(); rst_n = 1'b1; psum_val = 1'b0; ctrl = 32'h1;
    run_job($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(4, 20), 70, 0, 0, 0);
  endtask

  // Soft clear mid-RUN with the underrun flag set, then a clean job.
  task automatic test_soft_clear();
    cfg_wi = 1; cfg_ks = 1; cfg_np = 40;
    buf_full = 1'b1; buf_empty = 1'b1; psum_val = 1'b0;
    do_start();
    cyc(); psum_val = 1'b1;
    cyc(); psum_val = 1'b0;
    settle();
    chk_cnt++;
    if ({o_busy, o_err_underrun} !== 2'b11)
      $display("FAIL clear_pre: got busy%b err%b want 11", o_busy, o_err_underrun);
    else pass_cnt++;
    soft_clear();
    buf_empty = 1'b0;
    run_job($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(4, 20), 60, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fetch(3, 1);
    for (int k = 0; k < 3; k++) test_fetch($urandom_range(0, 5), $urandom_range(0, 3));
    test_preload();
    run_job(2, 1, 11, 100, 0, 0, 1);          // directed weight sequencing
    run_job(1, 1, 15, 100, 0, 1, 0);          // enb gap mid-run
    run_job(0, 2, 9, 100, 100, 0, 0);         // underrun sticky through done
    run_job(1, 0, 6, 100, 0, 0, 0);           // next start clears the flag
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 24),
              $urandom_range(40, 100), $urandom_range(0, 20), $urandom_range(0, 1), 0);
    test_reset_midburst();
    test_soft_clear();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
